// File: rtl/cacheline_adapter.sv
// Cache-line to banked-memory burst adapter: one line read is deserialized from
// BURST_LEN returning beats, one line write is serialized into BURST_LEN beats.
module cacheline_adapter #(
  parameter int ADDR_W    = 32,
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4,
  localparam int LINE_W   = BEAT_W * BURST_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dfp_addr,
  input  logic              dfp_read,
  input  logic              dfp_write,
  input  logic [LINE_W-1:0] dfp_wdata,
  output logic [LINE_W-1:0] dfp_rdata,
  output logic              dfp_resp,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_BEAT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [LINE_W-1:0] line_q;     // write data on writes, partial line on reads
  logic [LINE_W-1:0] rd_line;
  logic [BEAT_W-1:0] next_wbeat;
  logic [ADDR_W-1:0] line_addr;
  logic              beat_hit;
  logic              addr_unused;

  assign line_addr   = {dfp_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign addr_unused = ^dfp_addr[OFF_W-1:0];
  assign cnt_inc     = cnt + CNT_W'(1);
  // bmem_addr holds the latched line address for the whole operation.
  assign beat_hit    = bmem_rvalid && (bmem_raddr == bmem_addr);

  // NOTE: every variable gets a full default first, so no latch is inferred.
  always_comb begin
    rd_line = line_q;
    rd_line[cnt*BEAT_W +: BEAT_W] = bmem_rdata;
    next_wbeat = line_q[cnt_inc*BEAT_W +: BEAT_W];
  end

  // NOTE: the line buffer is reset too, so no stale data is visible after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      line_q     <= '0;
      dfp_rdata  <= '0;
      dfp_resp   <= 1'b0;
      bmem_addr  <= '0;
      bmem_read  <= 1'b0;
      bmem_write <= 1'b0;
      bmem_wdata <= '0;
    end else begin
      dfp_resp <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dfp_read) begin
            bmem_addr <= line_addr;
            bmem_read <= 1'b1;
            state     <= RD_REQ;
          end else if (dfp_write) begin
            bmem_addr  <= line_addr;
            line_q     <= dfp_wdata;
            bmem_write <= 1'b1;
            bmem_wdata <= dfp_wdata[BEAT_W-1:0];
            state      <= WR_BEAT;
          end
        end
        RD_REQ: begin
          if (bmem_ready) begin
            bmem_read <= 1'b0;
            state     <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (beat_hit) begin
            line_q <= rd_line;
            if (cnt == LAST_BEAT) begin
              cnt       <= '0;
              dfp_rdata <= rd_line;
              dfp_resp  <= 1'b1;
              state     <= RESP;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        WR_BEAT: begin
          if (bmem_ready) begin
            if (cnt == LAST_BEAT) begin
              cnt        <= '0;
              bmem_write <= 1'b0;
              dfp_resp   <= 1'b1;
              state      <= RESP;
            end else begin
              cnt        <= cnt_inc;
              bmem_wdata <= next_wbeat;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_one_dfp_op: assert property (@(posedge clk) disable iff (!rst_n)
    !(dfp_read && dfp_write));
  a_one_bmem_op: assert property (@(posedge clk) disable iff (!rst_n)
    !(bmem_read && bmem_write));

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter: expected write beats and line
// responses are queued at request time and compared as the DUT produces them.
module tb_cacheline_adapter;

  localparam int ADDR_W    = 32;
  localparam int BEAT_W    = 64;
  localparam int BURST_LEN = 4;
  localparam int LINE_W    = BEAT_W * BURST_LEN;

  localparam logic [BEAT_W-1:0] BA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [BEAT_W-1:0] BB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [BEAT_W-1:0] BC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [BEAT_W-1:0] BD = 64'hDDDD_DDDD_DDDD_DDDD;

  logic              clk, rst_n;
  logic [ADDR_W-1:0] dfp_addr;
  logic              dfp_read, dfp_write;
  logic [LINE_W-1:0] dfp_wdata, dfp_rdata;
  logic              dfp_resp;
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read, bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  cacheline_adapter #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
    .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              is_read;
    logic [LINE_W-1:0] line;
  } resp_t;

  resp_t             resp_q[$];
  logic [BEAT_W-1:0] wbeat_q[$];
  resp_t             mon_r;
  logic [ADDR_W-1:0] exp_addr;
  logic [LINE_W-1:0] last_line;
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int rd_cycles, wr_cycles, t_req, at, t_beat;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Monitor samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bmem_read)  rd_cycles++;
      if (bmem_write) wr_cycles++;
      if (bmem_read && bmem_write) check("rd_wr_overlap", 1, 0);
      if (bmem_write && bmem_ready) begin
        if (wbeat_q.size() == 0) check("wr_extra_beat", 1, 0);
        else begin
          check("wr_beat", bmem_wdata, wbeat_q.pop_front());
          check("wr_addr", bmem_addr, exp_addr);
        end
      end
      if (dfp_resp) begin
        if (resp_q.size() == 0) check("resp_extra", 1, 0);
        else begin
          mon_r = resp_q.pop_front();
          if (mon_r.is_read) last_line = mon_r.line;
          check(mon_r.is_read ? "rd_line" : "rdata_kept", dfp_rdata, last_line);
        end
      end
    end
  end

  // NOTE: inputs change 1 time unit after the rising edge, with blocking writes.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_beat(input logic [ADDR_W-1:0] ra, input logic [BEAT_W-1:0] d);
    tick();
    bmem_rvalid = 1'b1;
    bmem_raddr  = ra;
    bmem_rdata  = d;
  endtask

  task automatic no_beat();
    tick();
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  task automatic start_read(input logic [ADDR_W-1:0] addr,
                            input logic [LINE_W-1:0] line, input bit expect_resp);
    tick();
    dfp_addr  = addr;
    dfp_read  = 1'b1;
    exp_addr  = {addr[ADDR_W-1:5], 5'b0};
    rd_cycles = 0;
    t_req     = cyc;
    if (expect_resp) resp_q.push_back('{is_read: 1'b1, line: line});
  endtask

  task automatic start_write(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] wd);
    tick();
    dfp_addr  = addr;
    dfp_write = 1'b1;
    dfp_wdata = wd;
    exp_addr  = {addr[ADDR_W-1:5], 5'b0};
    wr_cycles = 0;
    t_req     = cyc;
    for (int i = 0; i < BURST_LEN; i++) wbeat_q.push_back(wd[i*BEAT_W +: BEAT_W]);
    resp_q.push_back('{is_read: 1'b0, line: '0});
  endtask

  task automatic wait_resp(input int budget, output int seen);
    seen = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dfp_resp) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) check("resp_timeout", 0, 1);
  endtask

  task automatic end_req();
    tick();
    dfp_read  = 1'b0;
    dfp_write = 1'b0;
    @(negedge clk);
    check("resp_pulse", dfp_resp, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    last_line = '0; exp_addr = '0; rd_cycles = 0; wr_cycles = 0;
    #3;
    check("rst_resp",  dfp_resp, 0);
    check("rst_bmem",  {bmem_read, bmem_write}, 0);
    check("rst_addr",  bmem_addr, 0);
    check("rst_wdata", bmem_wdata, 0);
    check("rst_rdata", dfp_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bmem_ready = 1'b1;

    // Plain read with a 5-cycle memory delay.
    start_read(32'h1ECE_B004, {BD, BC, BB, BA}, 1'b1);
    @(negedge clk);
    check("rd_idle", bmem_read, 0);
    tick();
    @(negedge clk);
    check("rd_req",  bmem_read, 1);
    check("rd_addr", bmem_addr, 32'h1ECE_B000);
    repeat (5) no_beat();
    put_beat(32'h1ECE_B000, BA);
    put_beat(32'h1ECE_B000, BB);
    put_beat(32'h1ECE_B000, BC);
    put_beat(32'h1ECE_B000, BD);
    t_beat = cyc;
    no_beat();
    wait_resp(8, at);
    check("rd_lat", at, t_beat + 1);
    check("rd_req_cycles", rd_cycles, 1);
    end_req();

    // Plain write right after the read; the read line must survive it.
    start_write(32'h1000_0010, {64'h4, 64'h3, 64'h2, 64'h1});
    wait_resp(16, at);
    check("wr_lat", at, t_req + 5);
    check("wr_cycles", wr_cycles, 4);
    end_req();

    // Read with the request stalled for 3 cycles.
    start_read(32'h2000_0000, {BA, BB, BC, BD}, 1'b1);
    bmem_ready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rd_hold", {bmem_read, bmem_addr}, {1'b1, 32'h2000_0000});
    repeat (2) tick();
    bmem_ready = 1'b1;
    put_beat(32'h2000_0000, BD);
    put_beat(32'h2000_0000, BC);
    put_beat(32'h2000_0000, BB);
    put_beat(32'h2000_0000, BA);
    no_beat();
    wait_resp(8, at);
    check("rd_stall_cycles", rd_cycles, 4);
    end_req();

    // Write with beat 2 stalled for 3 cycles.
    start_write(32'h2000_0047, {64'h44, 64'h33, 64'h22, 64'h11});
    repeat (3) tick();
    bmem_ready = 1'b0;
    tick();
    @(negedge clk);
    check("wr_hold", {bmem_write, bmem_wdata}, {1'b1, 64'h33});
    repeat (2) tick();
    bmem_ready = 1'b1;
    wait_resp(16, at);
    check("wr_stall_lat", at, t_req + 8);
    check("wr_stall_cycles", wr_cycles, 7);
    end_req();

    // Filtering: beat during RD_REQ, rvalid gap, stray address.
    start_read(32'h3000_0000, {BD, BC, BB, BA}, 1'b1);
    put_beat(32'h3000_0000, 64'hDEAD_0000_0000_0001);
    put_beat(32'h3000_0000, BA);
    put_beat(32'h3000_0000, BB);
    put_beat(32'h0000_0040, 64'hDEAD_0000_0000_0002);
    no_beat();
    put_beat(32'h3000_0000, BC);
    put_beat(32'h3000_0000, BD);
    no_beat();
    wait_resp(8, at);
    end_req();

    // Reset in the middle of a read after two beats.
    start_read(32'h0000_0080, '0, 1'b0);
    no_beat();
    put_beat(32'h0000_0080, 64'h1111);
    put_beat(32'h0000_0080, 64'h2222);
    tick();
    rst_n = 1'b0; dfp_read = 1'b0; bmem_rvalid = 1'b0;
    #1;
    check("abort_outputs", {dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata}, 0);
    check("abort_rdata", dfp_rdata, 0);
    last_line = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    start_read(32'h0000_0080, {64'h8, 64'h7, 64'h6, 64'h5}, 1'b1);
    no_beat();
    no_beat();
    put_beat(32'h0000_0080, 64'h5);
    put_beat(32'h0000_0080, 64'h6);
    put_beat(32'h0000_0080, 64'h7);
    put_beat(32'h0000_0080, 64'h8);
    no_beat();
    wait_resp(8, at);
    end_req();

    // Back-to-back write after the read must leave dfp_rdata alone.
    start_write(32'h0000_00A0, {64'hF4, 64'hF3, 64'hF2, 64'hF1});
    wait_resp(16, at);
    end_req();
    check("rdata_after_wr", dfp_rdata, {64'h8, 64'h7, 64'h6, 64'h5});
    check("sb_empty", resp_q.size() + wbeat_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
